// File: rtl/hazard_pkg.sv
// Shared types and sizing helpers for the hazard controller.
package hazard_pkg;

  typedef enum logic [2:0] {
    ST_NOR    = 3'd0,
    ST_CTRL   = 3'd1,
    ST_STRUCT = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_DATA   = 3'd4
  } hz_state_e;

  // Largest stall/flush length the timer is ever sized for.
  localparam int MAX_LAT = 7;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int timer_w(input int load_lat, input int flush_len);
    int m;
    m = max2(load_lat, flush_len);
    if (m > MAX_LAT) m = MAX_LAT;
    if (m < 1) m = 1;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_gen_if.sv
// Hazard request/control bus between decode logic and the hazard controller.
interface hazard_ctrl_gen_if #(
  parameter int LANES = 2,
  parameter int CNT_W = 8
);
  logic [LANES-1:0] data_haz;
  logic [LANES-1:0] fwd_ok;
  logic             struct_busy;
  logic             ctrl_pend;
  logic             br_valid;
  logic             br_correct;
  logic             resolved;
  logic             pc_freeze;
  logic             do_flush;
  logic [LANES-1:0] lane_hold;
  logic [2:0]       state;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output data_haz, fwd_ok, struct_busy, ctrl_pend, br_valid, br_correct,
    input  resolved, pc_freeze, do_flush, lane_hold, state, stall_cnt
  );

  modport slave (
    input  data_haz, fwd_ok, struct_busy, ctrl_pend, br_valid, br_correct,
    output resolved, pc_freeze, do_flush, lane_hold, state, stall_cnt
  );
endinterface

// File: rtl/hazard_timer.sv
// Loadable down-counter shared by the DATA stall and FLUSH windows.
module hazard_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] cnt;

  // Decrement stops at zero so the counter can never wrap.
  always_ff @(posedge clk) begin
    if (rst)                     cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (dec && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/hazard_ctrl_gen.sv
// Multi-lane pipeline hazard controller: control, load-use and structural stalls.
// Optional HAZARD_STATS_EN compiles in a saturating stall-cycle counter.
module hazard_ctrl_gen
  import hazard_pkg::*;
#(
  parameter int LANES     = 2,
  parameter int LOAD_LAT  = 2,
  parameter int FLUSH_LEN = 1,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  hazard_ctrl_gen_if.slave  bus
);
  localparam int TW = timer_w(LOAD_LAT, FLUSH_LEN);
  localparam logic [TW-1:0] LD_DATA  = TW'(LOAD_LAT - 1);
  localparam logic [TW-1:0] LD_FLUSH = TW'(FLUSH_LEN - 1);

  hz_state_e        state_q, state_d;
  logic [LANES-1:0] mask_q, mask_d;
  logic [LANES-1:0] uh;
  logic             any_uh;
  logic             t_load, t_dec, t_zero;
  logic [TW-1:0]    t_val;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign uh[l] = bus.data_haz[l] & ~bus.fwd_ok[l];
  end
  assign any_uh = |uh;

  hazard_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .dec      (t_dec),
    .zero     (t_zero)
  );

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    t_load  = 1'b0;
    t_val   = '0;
    t_dec   = 1'b0;
    case (state_q)
      ST_NOR: begin
        if (bus.ctrl_pend) state_d = ST_CTRL;
        else if (any_uh) begin
          state_d = ST_DATA;
          mask_d  = uh;
          t_load  = 1'b1;
          t_val   = LD_DATA;
        end else if (bus.struct_busy) state_d = ST_STRUCT;
      end
      ST_CTRL: begin
        if (bus.br_valid && !bus.br_correct) begin
          state_d = ST_FLUSH;
          t_load  = 1'b1;
          t_val   = LD_FLUSH;
        end else if (bus.br_valid) begin
          // Correct prediction: fall through to the idle priority minus ctrl_pend.
          if (any_uh) begin
            state_d = ST_DATA;
            mask_d  = uh;
            t_load  = 1'b1;
            t_val   = LD_DATA;
          end else if (bus.struct_busy) state_d = ST_STRUCT;
          else                          state_d = ST_NOR;
        end else if (!bus.ctrl_pend) state_d = ST_NOR;
      end
      ST_STRUCT: begin
        if (bus.br_valid && !bus.br_correct) begin
          state_d = ST_FLUSH;
          t_load  = 1'b1;
          t_val   = LD_FLUSH;
        end else if (!bus.struct_busy || bus.br_valid) state_d = ST_NOR;
      end
      ST_DATA: begin
        t_dec = 1'b1;
        if (any_uh) begin
          // A fresh uncovered hazard widens the hold set and restarts the stall.
          mask_d = mask_q | uh;
          t_load = 1'b1;
          t_val  = LD_DATA;
        end else if (t_zero) begin
          state_d = bus.ctrl_pend ? ST_CTRL : ST_NOR;
          mask_d  = '0;
        end
      end
      ST_FLUSH: begin
        t_dec = 1'b1;
        if (t_zero) state_d = bus.ctrl_pend ? ST_CTRL : ST_NOR;
      end
      default: begin
        state_d = ST_NOR;
        mask_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_NOR;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.resolved  = (state_q == ST_NOR);
  assign bus.pc_freeze = (state_q != ST_NOR);
  assign bus.do_flush  = (state_q == ST_FLUSH);
  assign bus.lane_hold = (state_q == ST_DATA) ? mask_q : '0;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                                 cnt_q <= '0;
    else if (bus.pc_freeze && !(&cnt_q))     cnt_q <= cnt_q + 1'b1;
  end

  assign bus.stall_cnt = cnt_q;
`else
  assign bus.stall_cnt = {CNT_W{1'b0}};
`endif

endmodule
